// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the memory access unit.
// Size encoding, FSM state enum and byte-enable helpers.
package mem_access_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } state_t;

  function automatic logic [7:0] byte_en(
    input logic [1:0] sz,
    input logic [2:0] lane
  );
    logic [7:0] base;
    unique case (sz)
      SZ_B:    base = 8'h01;
      SZ_H:    base = 8'h03;
      SZ_W:    base = 8'h0f;
      default: base = 8'hff;
    endcase
    return base << lane;
  endfunction

  function automatic logic misaligned(
    input logic [1:0] sz,
    input logic [2:0] a
  );
    logic m;
    unique case (sz)
      SZ_B:    m = 1'b0;
      SZ_H:    m = a[0];
      SZ_W:    m = |a[1:0];
      default: m = |a[2:0];
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Load data alignment: shift the addressed lane down, truncate to
// size, then sign- or zero-extend. Ports: rdata, lane, size, sign_ext -> result.
module load_align
  import mem_access_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LW     = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [LW-1:0]     lane,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  output logic [DATA_W-1:0] result
);

  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] keep;
  logic              msb;

  always_comb begin
    shifted = rdata >> {lane, 3'b000};
    keep    = ~({DATA_W{1'b1}} << (8 << size));
    unique case (size)
      SZ_B:    msb = shifted[7];
      SZ_H:    msb = shifted[15];
      SZ_W:    msb = shifted[31];
      default: msb = shifted[DATA_W-1];
    endcase
    result = shifted & keep;
    if (sign_ext && msb) begin
      result = result | ~keep;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Clocked load/store unit with req/ack memory port, misalignment
// detection and ack timeout. Ports: pipeline in_valid/in_ready/done/err,
// operation fields, ldresult, and the mem_* request/response port.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                isld,
  input  logic                isst,
  input  logic [1:0]          size,
  input  logic                sign_ext,
  input  logic [ADDR_W-1:0]   aluresult,
  input  logic [DATA_W-1:0]   op2,
  output logic                done,
  output logic                err,
  output logic [DATA_W-1:0]   ldresult,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack
);

  localparam int NB = DATA_W / 8;
  localparam int LW = $clog2(NB);

  state_t            state;
  logic [7:0]        cnt;
  logic [LW-1:0]     lane_q;
  logic [1:0]        sz_q;
  logic              sx_q;
  logic              ld_q;
  logic [DATA_W-1:0] aligned;

  logic              bad;
  logic              bubble;
  logic              go;
  logic [7:0]        be_full;
  logic [DATA_W-1:0] wrep;

  always_comb begin
    bad = (isld && isst)
        || (size == SZ_D && DATA_W == 32)
        || misaligned(size, aluresult[2:0]);
    bubble = !bad && !isld && !isst;
    go     = !bad && (isld ^ isst);
    be_full = byte_en(size, 3'(aluresult[LW-1:0]));
  end

  // Replicate the low 1/2/4/8 bytes of op2 across every lane.
  always_comb begin
    int nb;
    wrep = '0;
    nb   = 1 << size;
    for (int i = 0; i < NB; i++) begin
      wrep[8*i +: 8] = op2[8*(i % nb) +: 8];
    end
  end

  load_align #(
    .DATA_W (DATA_W),
    .LW     (LW)
  ) u_align (
    .rdata    (mem_rdata),
    .lane     (lane_q),
    .size     (sz_q),
    .sign_ext (sx_q),
    .result   (aligned)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
      ldresult  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      cnt       <= '0;
      lane_q    <= '0;
      sz_q      <= SZ_B;
      sx_q      <= 1'b0;
      ld_q      <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            lane_q   <= aluresult[LW-1:0];
            sz_q     <= size;
            sx_q     <= sign_ext;
            ld_q     <= isld;
            cnt      <= '0;
            unique case (1'b1)
              bad: begin
                state    <= RESP;
                done     <= 1'b1;
                err      <= 1'b1;
                ldresult <= '0;
              end
              bubble: begin
                state    <= RESP;
                done     <= 1'b1;
                ldresult <= '0;
              end
              go: begin
                state     <= REQ;
                mem_req   <= 1'b1;
                mem_we    <= isst;
                mem_addr  <= aluresult & ~ADDR_W'(NB - 1);
                mem_be    <= be_full[NB-1:0];
                mem_wdata <= wrep;
              end
              default: ;
            endcase
          end
        end
        REQ: begin
          // Ack on the final allowed cycle still completes normally.
          if (mem_ack) begin
            state    <= RESP;
            done     <= 1'b1;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            ldresult <= ld_q ? aligned : '0;
          end else if (cnt == 8'(TIMEOUT - 1)) begin
            state    <= RESP;
            done     <= 1'b1;
            err      <= 1'b1;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            ldresult <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RESP: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a 32-bit unit with TIMEOUT=4
// and a 64-bit unit, checked against hand-computed values.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  logic        in_valid = 0, isld = 0, isst = 0, sign_ext = 0;
  logic [1:0]  size = 0;
  logic [31:0] aluresult = 0, op2 = 0, mem_rdata = 0;
  logic        mem_ack = 0;
  logic        in_ready, done, err, mem_req, mem_we;
  logic [31:0] ldresult, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  logic        d_in_valid = 0, d_isld = 0, d_isst = 0, d_sign_ext = 0;
  logic [1:0]  d_size = 0;
  logic [31:0] d_aluresult = 0, d_mem_addr;
  logic [63:0] d_op2 = 0, d_mem_rdata = 0, d_ldresult, d_mem_wdata;
  logic        d_mem_ack = 0;
  logic        d_in_ready, d_done, d_err, d_mem_req, d_mem_we;
  logic [7:0]  d_mem_be;

  mem_access_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(4)) u32 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .isld(isld), .isst(isst), .size(size), .sign_ext(sign_ext),
    .aluresult(aluresult), .op2(op2),
    .done(done), .err(err), .ldresult(ldresult),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  mem_access_unit #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(16)) u64 (
    .clk(clk), .reset(reset),
    .in_valid(d_in_valid), .in_ready(d_in_ready),
    .isld(d_isld), .isst(d_isst), .size(d_size), .sign_ext(d_sign_ext),
    .aluresult(d_aluresult), .op2(d_op2),
    .done(d_done), .err(d_err), .ldresult(d_ldresult),
    .mem_req(d_mem_req), .mem_we(d_mem_we), .mem_addr(d_mem_addr),
    .mem_wdata(d_mem_wdata), .mem_be(d_mem_be),
    .mem_rdata(d_mem_rdata), .mem_ack(d_mem_ack)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op32(input logic ld, input logic st, input logic [1:0] sz,
                      input logic sx, input logic [31:0] a);
    isld = ld; isst = st; size = sz; sign_ext = sx; aluresult = a;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  int n;

  initial begin
    tick(); tick();
    check("rst_ready", in_ready, 1);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_ldres", ldresult, 0);
    check("rst_req", mem_req, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_be", mem_be, 0);
    reset = 1'b0;
    tick();

    // word store, ack in 4th REQ cycle (also the timeout boundary)
    isst = 1; isld = 0; size = 2; aluresult = 32'h100; op2 = 32'hDEADBEEF;
    in_valid = 1;
    tick();
    aluresult = 32'h400;
    check("st_addr", mem_addr, 32'h100);
    check("st_be", mem_be, 4'hF);
    check("st_wdata", mem_wdata, 32'hDEADBEEF);
    check("st_we", mem_we, 1);
    check("st_busy", in_ready, 0);
    for (int i = 0; i < 4; i++) begin
      check("st_req_hold", mem_req, 1);
      mem_ack = (i == 3);
      tick();
    end
    check("st_addr_stable", mem_addr, 32'h100);
    mem_ack = 0; in_valid = 0;
    check("st_done", done, 1);
    check("st_err", err, 0);
    check("st_req_drop", mem_req, 0);
    check("st_ldres", ldresult, 0);
    tick();
    check("st_done_pulse", done, 0);
    check("st_ready", in_ready, 1);

    // byte store replication
    op2 = 32'h000000A5;
    op32(0, 1, 0, 0, 32'h102);
    check("sb_wdata", mem_wdata, 32'hA5A5A5A5);
    check("sb_be", mem_be, 4'h4);
    check("sb_addr", mem_addr, 32'h100);
    mem_ack = 1; tick(); mem_ack = 0;
    check("sb_done", done, 1);
    tick();

    // byte load 0x203, sign-extended, zero-wait
    op32(1, 0, 0, 1, 32'h203);
    check("lb_be", mem_be, 4'h8);
    check("lb_we", mem_we, 0);
    mem_ack = 1; mem_rdata = 32'h80123456;
    tick();
    mem_ack = 0;
    check("lb_done_c2", done, 1);
    check("lb_err", err, 0);
    check("lb_data", ldresult, 32'hFFFFFF80);
    tick();
    check("lb_ready_c3", in_ready, 1);
    check("lb_hold", ldresult, 32'hFFFFFF80);

    // half load 0x202, zero-extended
    op32(1, 0, 1, 0, 32'h202);
    check("lh_be", mem_be, 4'hC);
    mem_ack = 1; tick(); mem_ack = 0;
    check("lh_data", ldresult, 32'h00008012);
    tick();

    // misaligned half load
    op32(1, 0, 1, 0, 32'h101);
    check("mis_req", mem_req, 0);
    check("mis_done", done, 1);
    check("mis_err", err, 1);
    tick();
    check("mis_req2", mem_req, 0);

    // ld and st both set
    op32(1, 1, 2, 0, 32'h100);
    check("ldst_err", err, 1);
    check("ldst_req", mem_req, 0);
    tick();

    // double at 32-bit width
    op32(1, 0, 3, 0, 32'h108);
    check("dbl32_err", err, 1);
    tick();

    // reload a nonzero result, then a bubble clears it
    op32(1, 0, 0, 1, 32'h203);
    mem_ack = 1; tick(); mem_ack = 0;
    tick();
    op32(0, 0, 2, 0, 32'h0);
    check("bub_done", done, 1);
    check("bub_err", err, 0);
    check("bub_ldres", ldresult, 0);
    check("bub_req", mem_req, 0);
    tick();

    // timeout
    op32(1, 0, 0, 1, 32'h203);
    mem_ack = 1; tick(); mem_ack = 0;
    tick();
    op32(1, 0, 2, 0, 32'h300);
    n = 0;
    while (mem_req && n < 20) begin
      n++;
      tick();
    end
    check("to_req_cycles", n, 4);
    check("to_done", done, 1);
    check("to_err", err, 1);
    check("to_ldres", ldresult, 0);
    tick();

    // ack outside REQ ignored
    mem_ack = 1; tick(); mem_ack = 0;
    check("ack_idle_done", done, 0);
    check("ack_idle_req", mem_req, 0);

    // reset in second REQ cycle with a pending ack
    op32(1, 0, 2, 0, 32'h300);
    tick();
    check("rs_req_before", mem_req, 1);
    reset = 1; mem_ack = 1;
    tick();
    reset = 0; mem_ack = 0;
    check("rs_req", mem_req, 0);
    check("rs_done", done, 0);
    check("rs_ready", in_ready, 1);
    tick();
    check("rs_done_after", done, 0);

    // 64-bit double load from 0x8
    d_isld = 1; d_size = 3; d_sign_ext = 0; d_aluresult = 32'h8;
    d_in_valid = 1;
    tick();
    d_in_valid = 0;
    check("d_be", d_mem_be, 8'hFF);
    check("d_addr", d_mem_addr, 32'h8);
    d_mem_ack = 1; d_mem_rdata = 64'h0123456789ABCDEF;
    tick();
    d_mem_ack = 0;
    check("d_done", d_done, 1);
    check("d_data", d_ldresult, 64'h0123456789ABCDEF);
    tick();

    // 64-bit word load from 0xC, sign-extended upper lane
    d_size = 2; d_sign_ext = 1; d_aluresult = 32'hC;
    d_in_valid = 1;
    tick();
    d_in_valid = 0;
    check("dw_be", d_mem_be, 8'hF0);
    check("dw_addr", d_mem_addr, 32'h8);
    d_mem_ack = 1; d_mem_rdata = 64'h89ABCDEF_01234567;
    tick();
    d_mem_ack = 0;
    check("dw_data", d_ldresult, 64'hFFFFFFFF89ABCDEF);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
